// File: rtl/io_pkg.sv
// Shared definitions for the input-capture stage in front of the processor I/O module:
// FSM state encoding and the default bus widths.
package io_pkg;

   localparam int DATA_W          = 13;
   localparam int OUT_W           = 32;
   localparam int DEBOUNCE_CYCLES = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      DEBOUNCE = 3'd2,
      CAPTURED = 3'd3,
      RELEASE  = 3'd4
   } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for signals that are asynchronous to the clock.
// Every bit is synchronised on its own; multi-bit values must be held stable for it to settle.
module sincronizador_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] etapa1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         etapa1 <= '0;
         q      <= '0;
      end else begin
         etapa1 <= d;
         q      <= etapa1;
      end
   end

endmodule

// File: rtl/captura_entrada_io.sv
// Debounced capture of the board switches: one switch word per press of Set,
// offered to the I/O module only while it has an IN instruction pending.
module captura_entrada_io #(
   parameter int DATA_W          = io_pkg::DATA_W,
   parameter int DEBOUNCE_CYCLES = io_pkg::DEBOUNCE_CYCLES,
   parameter int OUT_W           = io_pkg::OUT_W
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [DATA_W-1:0]   Switches,
   input  logic                Set,
   input  logic                Request,
   input  logic                Ack,
   output logic                DataValid,
   output logic [OUT_W-1:0]    DataIn,
   output logic                Waiting,
   output io_pkg::estado_t     state_dbg
);

   import io_pkg::*;

   // DEBOUNCE_CYCLES must be at least 2; the counter only ever holds 0..DEBOUNCE_CYCLES-1.
   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic               set_sync;
   logic [DATA_W-1:0]  sw_sync;
   estado_t            state;
   logic [CNT_W-1:0]   cnt;

   sincronizador_2ff #(.W(1)) u_sync_set (
      .clk   (Clock),
      .rst_n (Reset),
      .d     (Set),
      .q     (set_sync)
   );

   sincronizador_2ff #(.W(DATA_W)) u_sync_sw (
      .clk   (Clock),
      .rst_n (Reset),
      .d     (Switches),
      .q     (sw_sync)
   );

   // Handshake: DataValid rises with DataIn already stable and holds until the edge on
   // which Ack=1 (or Request=0) is seen; Ack without DataValid is ignored.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         DataValid <= 1'b0;
         DataIn    <= '0;
         Waiting   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (Request) begin
                  if (set_sync) begin
                     state <= RELEASE;
                  end else begin
                     state   <= ARMED;
                     Waiting <= 1'b1;
                  end
               end
            end

            ARMED: begin
               if (!Request) begin
                  state   <= IDLE;
                  Waiting <= 1'b0;
               end else if (set_sync) begin
                  state <= DEBOUNCE;
                  cnt   <= CNT_ONE;
               end
            end

            DEBOUNCE: begin
               if (!Request) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  Waiting <= 1'b0;
               end else if (!set_sync) begin
                  state <= ARMED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= CAPTURED;
                  cnt       <= '0;
                  DataValid <= 1'b1;
                  DataIn    <= OUT_W'(sw_sync);
                  Waiting   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // An abort (Request low) still forces a full release so one press never yields two words.
            CAPTURED: begin
               if (Ack || !Request) begin
                  state     <= RELEASE;
                  cnt       <= '0;
                  DataValid <= 1'b0;
               end
            end

            RELEASE: begin
               if (set_sync) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               cnt       <= '0;
               DataValid <= 1'b0;
               Waiting   <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_captura_entrada_io.sv
// Bench for captura_entrada_io: directed scenarios plus a random run, each checked against
// a run-length model of press/release behaviour.
module tb_captura_entrada_io;

   localparam int DW = 13;
   localparam int OW = 32;
   localparam int DB = 4;

   logic            Clock = 1'b0;
   logic            Reset;
   logic [DW-1:0]   Switches;
   logic            Set;
   logic            Request;
   logic            Ack;
   logic            DataValid;
   logic [OW-1:0]   DataIn;
   logic            Waiting;
   io_pkg::estado_t state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Model: raw-sample delay line plus "waiting / valid / must-release" flags and run lengths.
   logic            m_s1, m_s2;
   logic [DW-1:0]   m_sw1, m_sw2;
   logic            m_valid, m_waiting, m_release;
   logic [OW-1:0]   m_data;
   int              m_high, m_low;

   captura_entrada_io #(.DATA_W(DW), .DEBOUNCE_CYCLES(DB), .OUT_W(OW)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Switches  (Switches),
      .Set       (Set),
      .Request   (Request),
      .Ack       (Ack),
      .DataValid (DataValid),
      .DataIn    (DataIn),
      .Waiting   (Waiting),
      .state_dbg (state_dbg)
   );

   always #5 Clock = ~Clock;

   function automatic logic [2:0] m_state();
      if (m_valid)                    return 3'd3;
      else if (m_release)             return 3'd4;
      else if (m_waiting && m_high>0) return 3'd2;
      else if (m_waiting)             return 3'd1;
      else                            return 3'd0;
   endfunction

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_sw1 = '0; m_sw2 = '0;
      m_valid = 1'b0; m_waiting = 1'b0; m_release = 1'b0;
      m_data = '0; m_high = 0; m_low = 0;
   endtask

   // One clock edge of the model, using the inputs as they are just before the edge.
   task automatic model_edge();
      logic s;
      s = m_s2;
      if (m_valid) begin
         if (Ack || !Request) begin
            m_valid = 1'b0; m_release = 1'b1; m_low = 0;
         end
      end else if (m_release) begin
         m_low = s ? 0 : m_low + 1;
         if (m_low == DB) m_release = 1'b0;
      end else if (!m_waiting) begin
         if (Request) begin
            if (s) begin m_release = 1'b1; m_low = 0; end
            else begin m_waiting = 1'b1; m_high = 0; end
         end
      end else begin
         if (!Request) begin
            m_waiting = 1'b0; m_high = 0;
         end else if (s) begin
            m_high++;
            if (m_high == DB) begin
               m_valid = 1'b1; m_waiting = 1'b0; m_high = 0;
               m_data = {{(OW-DW){1'b0}}, m_sw2};
            end
         end else begin
            m_high = 0;
         end
      end
      m_s2 = m_s1; m_s1 = Set;
      m_sw2 = m_sw1; m_sw1 = Switches;
   endtask

   task automatic step();
      model_edge();
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      Reset = 1'b0; Set = 1'b0; Request = 1'b0; Ack = 1'b0; Switches = '0;
      model_reset();
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {1'b0, 1'b0, 32'h0, 3'd0})
         $display("FAIL reset: got v=%b w=%b d=%h st=%0d, expected all zero", DataValid, Waiting, DataIn, state_dbg);
      else n_pass++;
   endtask

   task automatic cleanup(input string tag);
      Request = 1'b0; Ack = 1'b0; Set = 1'b0;
      repeat (8) begin
         step();
         n_checks++;
         if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {m_valid, m_waiting, m_data, m_state()})
            $display("FAIL %s_cleanup cyc %0d: got v=%b w=%b d=%h st=%0d, expected v=%b w=%b d=%h st=%0d",
                     tag, cyc, DataValid, Waiting, DataIn, state_dbg, m_valid, m_waiting, m_data, m_state());
         else n_pass++;
      end
   endtask

   task automatic test_basic_press();
      int lat, first;
      Request = 1'b1; Set = 1'b0; Ack = 1'b0; Switches = 13'h0A5;
      repeat (3) step();
      Set = 1'b1; lat = 0; first = 0;
      repeat (12) begin
         step(); lat++;
         if (DataValid && first == 0) first = lat;
         n_checks++;
         if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {m_valid, m_waiting, m_data, m_state()})
            $display("FAIL basic cyc %0d: got v=%b w=%b d=%h st=%0d, expected v=%b w=%b d=%h st=%0d",
                     cyc, DataValid, Waiting, DataIn, state_dbg, m_valid, m_waiting, m_data, m_state());
         else n_pass++;
      end
      n_checks++;
      if (first !== 2 + DB) $display("FAIL basic_latency: got %0d, expected %0d", first, 2 + DB);
      else n_pass++;
      n_checks++;
      if (DataIn !== 32'h000000A5) $display("FAIL basic_data: got %h, expected 000000a5", DataIn);
      else n_pass++;
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      n_checks++;
      if (DataValid !== 1'b0 || state_dbg !== io_pkg::RELEASE)
         $display("FAIL basic_ack: got v=%b st=%0d, expected v=0 st=4", DataValid, state_dbg);
      else n_pass++;
      cleanup("basic");
   endtask

   task automatic test_bounce();
      logic pat [0:6];
      int caps;
      logic prev_v;
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      Request = 1'b1; Set = 1'b0; Switches = 13'h1234;
      repeat (3) step();
      caps = 0; prev_v = 1'b0;
      for (int i = 0; i < 14; i++) begin
         Set = (i < 7) ? pat[i] : 1'b1;
         step();
         if (DataValid && !prev_v) caps++;
         prev_v = DataValid;
         n_checks++;
         if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {m_valid, m_waiting, m_data, m_state()})
            $display("FAIL bounce cyc %0d: got v=%b w=%b d=%h st=%0d, expected v=%b w=%b d=%h st=%0d",
                     cyc, DataValid, Waiting, DataIn, state_dbg, m_valid, m_waiting, m_data, m_state());
         else n_pass++;
      end
      n_checks++;
      if (caps !== 1) $display("FAIL bounce_captures: got %0d, expected 1", caps);
      else n_pass++;
      Ack = 1'b1; step(); Ack = 1'b0;
      cleanup("bounce");
   endtask

   task automatic test_held_at_request();
      int caps;
      logic prev_v;
      Set = 1'b1; Switches = 13'h0777;
      repeat (4) step();
      Request = 1'b1;
      caps = 0; prev_v = 1'b0;
      for (int i = 0; i < 36; i++) begin
         if (i == 20) Set = 1'b0;
         if (i == 26) Set = 1'b1;
         step();
         if (DataValid && !prev_v) caps++;
         prev_v = DataValid;
         n_checks++;
         if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {m_valid, m_waiting, m_data, m_state()})
            $display("FAIL held cyc %0d: got v=%b w=%b d=%h st=%0d, expected v=%b w=%b d=%h st=%0d",
                     cyc, DataValid, Waiting, DataIn, state_dbg, m_valid, m_waiting, m_data, m_state());
         else n_pass++;
         if (i == 19) begin
            n_checks++;
            if (caps !== 0) $display("FAIL held_no_capture: got %0d captures, expected 0", caps);
            else n_pass++;
         end
      end
      n_checks++;
      if (caps !== 1) $display("FAIL held_repress: got %0d captures, expected 1", caps);
      else n_pass++;
      Ack = 1'b1; step(); Ack = 1'b0;
      cleanup("held");
   endtask

   task automatic test_one_word();
      int caps;
      logic prev_v;
      Request = 1'b1; Set = 1'b0; Switches = 13'h1F0F;
      repeat (3) step();
      Set = 1'b1;
      repeat (8) step();
      Ack = 1'b1; step(); Ack = 1'b0;
      Request = 1'b0; step(); Request = 1'b1;
      caps = 0; prev_v = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 12) Set = 1'b0;
         if (i == 20) Set = 1'b1;
         step();
         if (DataValid && !prev_v) caps++;
         prev_v = DataValid;
         n_checks++;
         if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {m_valid, m_waiting, m_data, m_state()})
            $display("FAIL oneword cyc %0d: got v=%b w=%b d=%h st=%0d, expected v=%b w=%b d=%h st=%0d",
                     cyc, DataValid, Waiting, DataIn, state_dbg, m_valid, m_waiting, m_data, m_state());
         else n_pass++;
         if (i == 11) begin
            n_checks++;
            if (caps !== 0) $display("FAIL oneword_held: got %0d captures, expected 0", caps);
            else n_pass++;
         end
      end
      n_checks++;
      if (caps !== 1) $display("FAIL oneword_repress: got %0d captures, expected 1", caps);
      else n_pass++;
      Ack = 1'b1; step(); Ack = 1'b0;
      cleanup("oneword");
   endtask

   task automatic test_abort();
      // Abort while debouncing.
      Request = 1'b1; Set = 1'b0; Switches = 13'h0055;
      repeat (3) step();
      Set = 1'b1;
      repeat (4) step();
      n_checks++;
      if (state_dbg !== io_pkg::DEBOUNCE) $display("FAIL abort_reach_debounce: got st=%0d, expected 2", state_dbg);
      else n_pass++;
      Request = 1'b0;
      step();
      n_checks++;
      if (state_dbg !== io_pkg::IDLE || Waiting !== 1'b0 || DataValid !== 1'b0)
         $display("FAIL abort_debounce: got st=%0d w=%b v=%b, expected st=0 w=0 v=0", state_dbg, Waiting, DataValid);
      else n_pass++;
      cleanup("abort1");
      // Abort while captured: DataIn keeps its value.
      Request = 1'b1; Switches = 13'h0ABC;
      repeat (3) step();
      Set = 1'b1;
      repeat (8) step();
      Request = 1'b0;
      step();
      n_checks++;
      if (DataValid !== 1'b0 || state_dbg !== io_pkg::RELEASE || DataIn !== 32'h00000ABC)
         $display("FAIL abort_captured: got v=%b st=%0d d=%h, expected v=0 st=4 d=00000abc", DataValid, state_dbg, DataIn);
      else n_pass++;
      cleanup("abort2");
      // Ack while idle does nothing.
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      n_checks++;
      if (state_dbg !== io_pkg::IDLE || DataValid !== 1'b0 || DataIn !== 32'h00000ABC)
         $display("FAIL ack_idle: got st=%0d v=%b d=%h, expected st=0 v=0 d=00000abc", state_dbg, DataValid, DataIn);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      Request = 1'b1; Set = 1'b0; Switches = 13'h1ACE;
      repeat (3) step();
      Set = 1'b1;
      repeat (8) step();
      n_checks++;
      if (DataValid !== 1'b1) $display("FAIL areset_precond: got v=%b, expected 1", DataValid);
      else n_pass++;
      #2;
      Reset = 1'b0;
      #1;
      n_checks++;
      if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {1'b0, 1'b0, 32'h0, 3'd0})
         $display("FAIL areset_immediate: got v=%b w=%b d=%h st=%0d, expected all zero", DataValid, Waiting, DataIn, state_dbg);
      else n_pass++;
      model_reset();
      Set = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      step();
      n_checks++;
      if (state_dbg !== io_pkg::ARMED || Waiting !== 1'b1)
         $display("FAIL areset_rearm: got st=%0d w=%b, expected st=1 w=1", state_dbg, Waiting);
      else n_pass++;
      cleanup("areset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) Set = ~Set;
         if (!Request) Request = ($urandom_range(0, 7) == 0);
         else if ($urandom_range(0, 39) == 0) Request = 1'b0;
         Ack = DataValid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) Switches = DW'($urandom);
         step();
         n_checks++;
         if ({DataValid, Waiting, DataIn, 3'(state_dbg)} !== {m_valid, m_waiting, m_data, m_state()})
            $display("FAIL random cyc %0d: got v=%b w=%b d=%h st=%0d, expected v=%b w=%b d=%h st=%0d",
                     cyc, DataValid, Waiting, DataIn, state_dbg, m_valid, m_waiting, m_data, m_state());
         else n_pass++;
         n_checks++;
         if (DataValid && Waiting) $display("FAIL random_exclusive cyc %0d: got v=1 w=1, expected not both", cyc);
         else n_pass++;
      end
      cleanup("random");
   endtask

   initial begin
      test_reset();
      test_basic_press();
      test_bounce();
      test_held_at_request();
      test_one_word();
      test_abort();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
